// File: rtl/fast_square_pkg.sv
// fast_square_pkg: shared constants and types for the fast-square link.
// Holds the restart marker word, the TX state enum, the default sample
// amplitude and the bit-to-sample mapping helper used by the TX unpacker.
package fast_square_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    // Marker word honoured on both receive and transmit paths.
    localparam logic [WORD_W-1:0] RESTART_WORD = 16'h8000;

    // Default magnitude of emitted samples (valid range 1..32767).
    localparam logic [WORD_W-1:0] DEFAULT_AMPLITUDE = 16'd8192;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } tx_state_e;

    // Map one packed bit to a signed sample: 1 -> +amp, 0 -> -amp (two's complement).
    function automatic logic [WORD_W-1:0] map_bit(input logic b, input logic [WORD_W-1:0] amp);
        return b ? amp : WORD_W'(WORD_W'(0) - amp);
    endfunction

endpackage

// File: rtl/fast_square_tx_unpack.sv
// fast_square_tx_unpack: one channel of the TX unpacker.
// Holds the active shift word, emits its MSB as a +/-amplitude sample and
// shifts left on every emit. The sample output is registered.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_i          take word_i into the shift register
//   word_i          word to load (oldest sample in bit 15)
//   emit_i          output the mapped MSB and shift left
//   zero_i          force the sample output to 0 (idle strobe or disabled)
//   flush_i         drop the shift contents
//   sample_o        registered signed sample
module fast_square_tx_unpack
    import fast_square_pkg::*;
#(
    parameter logic [15:0] AMPLITUDE = DEFAULT_AMPLITUDE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] word_i,
    input  logic        emit_i,
    input  logic        zero_i,
    input  logic        flush_i,
    output logic [15:0] sample_o
);

    logic [15:0] sh_q, sh_d;
    logic [15:0] sample_q, sample_d;

    // Next shift word: a load replaces the word even when the last bit of the
    // previous one is being emitted in the same cycle.
    always_comb begin
        sh_d     = sh_q;
        sample_d = sample_q;
        if (emit_i) begin
            sample_d = map_bit(sh_q[15], AMPLITUDE);
        end else if (zero_i) begin
            sample_d = 16'd0;
        end
        if (load_i) begin
            sh_d = word_i;
        end else if (flush_i) begin
            sh_d = 16'd0;
        end else if (emit_i) begin
            sh_d = {sh_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q     <= 16'd0;
            sample_q <= 16'd0;
        end else begin
            sh_q     <= sh_d;
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/fast_square_tx_bb.sv
// fast_square_tx_bb: transmit baseband unpacker for the fast-square link.
// Accepts packed 16-bit I/Q words (oldest sample in bit 15) into a one-entry
// holding buffer, moves them into per-channel shift registers and emits one
// +/-AMPLITUDE sample pair per enabled sample strobe.
// Optional feature: define FAST_SQUARE_TX_MARKER_EN to treat an accepted
// 16'h8000/16'h8000 pair as a restart marker (flush, back to IDLE, pulse
// restart_o, clear underrun). Without it the marker is ordinary data.
// Ports:
//   clock_i, reset_i           clock, synchronous active-high reset
//   enable_i                   low: strobes ignored, samples forced to 0
//   sample_strobe_i            one pulse per output sample
//   in_valid_i / in_ready_o    word-pair handshake (in_ready_o is combinational)
//   i_word_i, q_word_i         packed I/Q bits
//   i_out_o, q_out_o           registered signed samples
//   out_strobe_o               samples updated this cycle
//   underrun_o                 sticky: strobe with no data after a word ran out
//   restart_o                  one-cycle pulse after a marker is consumed
module fast_square_tx_bb
    import fast_square_pkg::*;
#(
    parameter logic [15:0] AMPLITUDE = DEFAULT_AMPLITUDE
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        sample_strobe_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] i_word_i,
    input  logic [15:0] q_word_i,
    output logic [15:0] i_out_o,
    output logic [15:0] q_out_o,
    output logic        out_strobe_o,
    output logic        underrun_o,
    output logic        restart_o
);

    tx_state_e        state_q;
    logic [15:0]      hold_i_q, hold_i_d;
    logic [15:0]      hold_q_q, hold_q_d;
    logic             hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic             active_q, active_d;
    logic             underrun_q, underrun_d;
    logic             out_strobe_q;
    logic             restart_q;

    logic strobe_en;
    logic accept;
    logic marker;
    logic store;
    logic emit;
    logic word_end;
    logic load;
    logic zero_out;

    assign in_ready_o = !hold_valid_q && !reset_i;
    assign accept     = in_valid_i && in_ready_o;
    assign strobe_en  = enable_i && sample_strobe_i;

`ifdef FAST_SQUARE_TX_MARKER_EN
    assign marker = accept && (i_word_i == RESTART_WORD) && (q_word_i == RESTART_WORD);
`else
    assign marker = 1'b0;
`endif

    assign store    = accept && !marker;
    assign emit     = strobe_en && active_q;
    assign word_end = emit && (bitcnt_q == CNT_W'(15));
    // Hold entry moves in when the shift pair is free or frees up this cycle.
    assign load     = hold_valid_q && (!active_q || word_end);
    // Idle strobe or disabled block drives zero samples.
    assign zero_out = !enable_i || (sample_strobe_i && !active_q);

    // Buffer, bit counter and sticky underrun next-state.
    always_comb begin
        hold_i_d     = hold_i_q;
        hold_q_d     = hold_q_q;
        hold_valid_d = hold_valid_q;
        bitcnt_d     = bitcnt_q;
        active_d     = active_q;
        underrun_d   = underrun_q;

        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (store) begin
            hold_valid_d = 1'b1;
            hold_i_d     = i_word_i;
            hold_q_d     = q_word_i;
        end

        if (load) begin
            bitcnt_d = '0;
            active_d = 1'b1;
        end else if (emit) begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (word_end) begin
                active_d = 1'b0;
            end
        end

        if (strobe_en && !active_q && (state_q == STARVED)) begin
            underrun_d = 1'b1;
        end

        // Marker discards the partial word and any pending entry.
        if (marker) begin
            hold_valid_d = 1'b0;
            active_d     = 1'b0;
            bitcnt_d     = '0;
            underrun_d   = 1'b0;
        end
    end

    // State machine and registered status outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            hold_i_q     <= 16'd0;
            hold_q_q     <= 16'd0;
            hold_valid_q <= 1'b0;
            bitcnt_q     <= '0;
            active_q     <= 1'b0;
            underrun_q   <= 1'b0;
            out_strobe_q <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            hold_i_q     <= hold_i_d;
            hold_q_q     <= hold_q_d;
            hold_valid_q <= hold_valid_d;
            bitcnt_q     <= bitcnt_d;
            active_q     <= active_d;
            underrun_q   <= underrun_d;
            out_strobe_q <= strobe_en;
            restart_q    <= marker;

            if (marker) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (load) state_q <= RUN;
                    RUN:     if (word_end && !load) state_q <= STARVED;
                    STARVED: if (load) state_q <= RUN;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    fast_square_tx_unpack #(
        .AMPLITUDE (AMPLITUDE)
    ) u_unpack_i (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .load_i   (load),
        .word_i   (hold_i_q),
        .emit_i   (emit),
        .zero_i   (zero_out),
        .flush_i  (marker),
        .sample_o (i_out_o)
    );

    fast_square_tx_unpack #(
        .AMPLITUDE (AMPLITUDE)
    ) u_unpack_q (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .load_i   (load),
        .word_i   (hold_q_q),
        .emit_i   (emit),
        .zero_i   (zero_out),
        .flush_i  (marker),
        .sample_o (q_out_o)
    );

    assign out_strobe_o = out_strobe_q;
    assign underrun_o   = underrun_q;
    assign restart_o    = restart_q;

endmodule

// File: tb/tb_fast_square_tx_bb.sv
// Testbench for fast_square_tx_bb: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// word/bit-index reference model.
module tb_fast_square_tx_bb;

    localparam logic [15:0] POS = 16'h2000;   // +8192
    localparam logic [15:0] NEG = 16'hE000;   // -8192

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        strobe = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] i_word = 16'd0;
    logic [15:0] q_word = 16'd0;
    logic        in_ready;
    logic [15:0] i_out, q_out;
    logic        out_strobe, underrun, restart;

    always #5 clock = ~clock;

    fast_square_tx_bb dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .enable_i        (enable),
        .sample_strobe_i (strobe),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .i_word_i        (i_word),
        .q_word_i        (q_word),
        .i_out_o         (i_out),
        .q_out_o         (q_out),
        .out_strobe_o    (out_strobe),
        .underrun_o      (underrun),
        .restart_o       (restart)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending word, current word with bit index.
    logic        m_hold_v = 1'b0;
    logic [15:0] m_hold_i = 16'd0, m_hold_q = 16'd0;
    logic        m_act = 1'b0;
    logic        m_started = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_cur_i = 16'd0, m_cur_q = 16'd0;
    logic [15:0] e_i = 16'd0, e_q = 16'd0;
    logic        e_stb = 1'b0, e_und = 1'b0, e_rst = 1'b0;

    task automatic model_step();
        logic acc, mk, emit, wend;
        int   idx;
        if (reset) begin
            m_hold_v = 1'b0; m_act = 1'b0; m_started = 1'b0; m_pos = 0;
            e_i = 16'd0; e_q = 16'd0; e_stb = 1'b0; e_und = 1'b0; e_rst = 1'b0;
            return;
        end
        acc = in_valid && !m_hold_v;
        mk  = 1'b0;
`ifdef FAST_SQUARE_TX_MARKER_EN
        mk = acc && (i_word == 16'h8000) && (q_word == 16'h8000);
`endif
        emit = enable && strobe && m_act;
        wend = emit && (m_pos == 15);
        e_stb = enable && strobe;
        if (!enable) begin
            e_i = 16'd0; e_q = 16'd0;
        end else if (strobe) begin
            if (m_act) begin
                idx = 15 - m_pos;
                e_i = m_cur_i[idx] ? POS : NEG;
                e_q = m_cur_q[idx] ? POS : NEG;
            end else begin
                e_i = 16'd0; e_q = 16'd0;
                if (m_started) e_und = 1'b1;
            end
        end
        if (emit) m_pos++;
        if (wend) m_act = 1'b0;
        if (m_hold_v && !m_act) begin
            m_cur_i = m_hold_i; m_cur_q = m_hold_q;
            m_pos = 0; m_act = 1'b1; m_started = 1'b1; m_hold_v = 1'b0;
        end
        if (acc && !mk) begin
            m_hold_v = 1'b1; m_hold_i = i_word; m_hold_q = q_word;
        end
        e_rst = mk;
        if (mk) begin
            m_act = 1'b0; m_started = 1'b0; m_pos = 0; e_und = 1'b0;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clock) begin
        model_step();
        #1;
        chk("i_out", i_out, e_i);
        chk("q_out", q_out, e_q);
        chk("out_strobe", 16'(out_strobe), 16'(e_stb));
        chk("underrun", 16'(underrun), 16'(e_und));
        chk("restart", 16'(restart), 16'(e_rst));
        chk("in_ready", 16'(in_ready), 16'(!m_hold_v && !reset));
    end

    task automatic cyc(input logic r, input logic en, input logic st, input logic v,
                       input logic [15:0] iw, input logic [15:0] qw);
        @(negedge clock);
        reset = r; enable = en; strobe = st; in_valid = v; i_word = iw; q_word = qw;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic send(input logic [15:0] iw, input logic [15:0] qw);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, iw, qw);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic stb();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    endtask

    logic [15:0] rec_i [32];
    logic [15:0] rec_q [32];
    logic        rec_u [32];
    logic [15:0] pat;
    int          cnt;

    initial begin
        // Reset state
        do_reset();
        do_reset();
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_i_out", i_out, 16'd0);
        chk("rst_out_strobe", 16'(out_strobe), 16'd0);
        chk("rst_underrun", 16'(underrun), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 16'(in_ready), 16'd1);

        // A5A5 / FFFF, 16 back-to-back strobes
        send(16'hA5A5, 16'hFFFF);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            stb();
            rec_i[k] = i_out; rec_q[k] = q_out;
            if (out_strobe) cnt++;
        end
        chk("a5_s0", rec_i[0], 16'h2000);
        chk("a5_s1", rec_i[1], 16'hE000);
        chk("a5_s2", rec_i[2], 16'h2000);
        chk("a5_s4", rec_i[4], 16'hE000);
        chk("a5_s15", rec_i[15], 16'h2000);
        chk("ff_q7", rec_q[7], 16'h2000);
        chk("a5_strobes", 16'(cnt), 16'd16);

        // Two pairs back to back, continuous strobes
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h9ABC, 16'hDEF0);
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1'b0, 1'b1, 1'b1, (k == 0), 16'h9ABC, 16'hDEF0);
            if (i_out == 16'd0 || q_out == 16'd0) cnt++;
        end
        chk("b2b_zero_samples", 16'(cnt), 16'd0);
        chk("b2b_underrun", 16'(underrun), 16'd0);

        // One pair, 20 strobes: last 4 starve
        do_reset();
        send(16'h0F0F, 16'hF0F0);
        for (int k = 0; k < 20; k++) begin
            stb();
            rec_i[k] = i_out; rec_u[k] = underrun;
        end
        chk("starve_s0", rec_i[0], 16'hE000);
        chk("starve_s16", rec_i[16], 16'd0);
        chk("starve_s19", rec_i[19], 16'd0);
        chk("underrun_at16", 16'(rec_u[15]), 16'd0);
        chk("underrun_at17", 16'(rec_u[16]), 16'd1);
        send(16'h8001, 16'h7FFE);
        stb();
        chk("resume_i", i_out, 16'h2000);
        chk("resume_q", q_out, 16'hE000);

`ifdef FAST_SQUARE_TX_MARKER_EN
        // Marker mid-word
        do_reset();
        send(16'hFFFF, 16'hFFFF);
        for (int k = 0; k < 8; k++) stb();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 16'h8000);
        chk("marker_restart", 16'(restart), 16'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        chk("marker_restart_once", 16'(restart), 16'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            stb();
            if (i_out == 16'hE000 && q_out == 16'hE000) cnt++;
        end
        chk("marker_zero_word", 16'(cnt), 16'd16);
        stb();
        chk("marker_dropped_ones", i_out, 16'd0);
`endif

        // Enable low mid-word
        do_reset();
        send(16'hC3C3, 16'h3C3C);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            stb(); rec_i[cnt] = i_out; rec_q[cnt] = q_out; cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
            chk("dis_strobe", 16'(out_strobe), 16'd0);
            chk("dis_i_out", i_out, 16'd0);
        end
        for (int k = 0; k < 12; k++) begin
            stb(); rec_i[cnt] = i_out; rec_q[cnt] = q_out; cnt++;
        end
        pat = 16'hC3C3;
        for (int k = 0; k < 16; k++) begin
            chk("en_resume_i", rec_i[k], pat[15-k] ? POS : NEG);
            chk("en_resume_q", rec_q[k], pat[15-k] ? NEG : POS);
        end

        // Reset mid-word
        do_reset();
        send(16'hFFFF, 16'h0000);
        for (int k = 0; k < 3; k++) stb();
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
            chk("midrst_i", i_out, 16'd0);
            chk("midrst_q", q_out, 16'd0);
            chk("midrst_strobe", 16'(out_strobe), 16'd0);
            chk("midrst_ready", 16'(in_ready), 16'd0);
        end
        stb();
        chk("post_rst_i", i_out, 16'd0);
        chk("post_rst_strobe", 16'(out_strobe), 16'd1);
        chk("post_rst_underrun", 16'(underrun), 16'd0);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            @(negedge clock);
            reset    = ($urandom_range(0, 399) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            strobe   = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                i_word = 16'h8000; q_word = 16'h8000;
            end else begin
                i_word = 16'($urandom); q_word = 16'($urandom);
            end
        end
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0; strobe = 1'b0;
        @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
